// File: rtl/smart_light_ctrl.sv
// smart_light_ctrl
//
// Multi-channel motion-activated lighting controller. Each channel takes a raw
// PIR sensor bit, synchronises and debounces it, and runs a detect/hold state
// machine that keeps the light on while motion is present and for a fixed
// hold time afterwards. Motion seen again during the hold time restarts it.
// A channel that is not enabled is held idle. A global override forces every
// light on without disturbing any channel's state.
//
// Ports
//   clk         system clock (single clock domain)
//   reset       synchronous, active-high reset
//   pir_in      raw asynchronous PIR inputs, one bit per channel
//   ch_enable   per-channel enable; 0 forces the channel to IDLE
//   force_on    global manual override; all lights on while high
//   led_out     registered light drive per channel
//   motion_evt  one-cycle pulse per accepted detection, per channel
//   any_active  registered OR of all channels that are not IDLE (ignores force_on)
//
// Channel FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no motion, light off (unless force_on)
//   DETECTED | filtered PIR high, light on
//   HOLD     | PIR has dropped, light kept on while hold counter runs down
//
// Timing: a PIR rise first sampled at edge 1 reaches the filtered level after
// edge DEB_CYCLES+2, and the light and event pulse appear after edge
// DEB_CYCLES+3. After the filtered level falls, the light stays on for
// HOLD_TIME+1 cycles in HOLD.

module smart_light_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int HOLD_TIME  = 50_000_000,
    parameter int CNT_W      = 26,
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pir_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              force_on,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] motion_evt,
    output logic              any_active
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DETECTED = 2'd1,
        S_HOLD     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TIME);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    // Input conditioning
    logic [NUM_CH-1:0] sync_1;
    logic [NUM_CH-1:0] sync_2;
    logic [NUM_CH-1:0] pir_f;
    logic [DEB_W-1:0]  deb_cnt [NUM_CH];

    // Channel state machines
    state_t            state      [NUM_CH];
    state_t            state_nxt  [NUM_CH];
    logic [CNT_W-1:0]  hold_cnt     [NUM_CH];
    logic [CNT_W-1:0]  hold_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] evt_nxt;
    logic [NUM_CH-1:0] active_nxt;

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw PIR pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= pir_in;
            sync_2 <= sync_1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: the filtered level only follows the synchronised input
    // after DEB_CYCLES consecutive samples that disagree with it. Any
    // agreeing sample restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pir_f <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_2[i] == pir_f[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    pir_f[i]   <= ~pir_f[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel FSM next-state logic. Disabling a channel overrides every
    // other transition and never produces an event.
    // ------------------------------------------------------------------
    always_comb begin
        evt_nxt    = '0;
        active_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i]    = state[i];
            hold_cnt_nxt[i] = hold_cnt[i];

            if (!ch_enable[i]) begin
                state_nxt[i] = S_IDLE;
            end else begin
                case (state[i])
                    S_IDLE: begin
                        if (pir_f[i]) begin
                            state_nxt[i] = S_DETECTED;
                            evt_nxt[i]   = 1'b1;
                        end
                    end
                    S_DETECTED: begin
                        if (!pir_f[i]) begin
                            state_nxt[i]    = S_HOLD;
                            hold_cnt_nxt[i] = HOLD_LOAD;
                        end
                    end
                    S_HOLD: begin
                        // Retrigger wins over expiry; the full hold time is
                        // reloaded when the filtered level next falls.
                        if (pir_f[i]) begin
                            state_nxt[i] = S_DETECTED;
                            evt_nxt[i]   = 1'b1;
                        end else if (hold_cnt[i] == '0) begin
                            state_nxt[i] = S_IDLE;
                        end else begin
                            hold_cnt_nxt[i] = hold_cnt[i] - 1'b1;
                        end
                    end
                    default: begin
                        state_nxt[i] = S_IDLE;
                    end
                endcase
            end

            active_nxt[i] = (state_nxt[i] != S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // State register and registered outputs. Outputs are taken from the
    // next-state values so the light follows a transition on the same edge.
    // Reset clears the lights even while force_on is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]    <= S_IDLE;
                hold_cnt[i] <= '0;
            end
            led_out    <= '0;
            motion_evt <= '0;
            any_active <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_cnt_nxt[i];
            end
            led_out    <= {NUM_CH{force_on}} | active_nxt;
            motion_evt <= evt_nxt;
            any_active <= |active_nxt;
        end
    end

endmodule

// File: tb/tb_smart_light_ctrl.sv
// tb_smart_light_ctrl
//
// Directed bench for smart_light_ctrl with NUM_CH=2, HOLD_TIME=10,
// DEB_CYCLES=4. A timestamp-based model predicts the outputs after every
// clock edge and a compare process checks them on the falling edge.
// Literal latencies and event counts are checked from the stimulus.

module tb_smart_light_ctrl;

    localparam int NUM_CH     = 2;
    localparam int HOLD_TIME  = 10;
    localparam int CNT_W      = 8;
    localparam int DEB_CYCLES = 4;
    localparam int DEB_W      = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] pir_in;
    logic [NUM_CH-1:0] ch_enable;
    logic              force_on;
    logic [NUM_CH-1:0] led_out;
    logic [NUM_CH-1:0] motion_evt;
    logic              any_active;

    smart_light_ctrl #(
        .NUM_CH     (NUM_CH),
        .HOLD_TIME  (HOLD_TIME),
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pir_in     (pir_in),
        .ch_enable  (ch_enable),
        .force_on   (force_on),
        .led_out    (led_out),
        .motion_evt (motion_evt),
        .any_active (any_active)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int ecnt       = 0;

    // ------------------------------------------------------------------
    // Reference model
    //   samp[n]   : pir_in captured at edge n
    //   pir_s seen at edge m is the sample of edge m-2 (zero straight after reset)
    //   filtered level flips at edge n when the last DEB_CYCLES pir_s values
    //   all disagree with it
    //   a channel leaving DETECTED at edge n turns off at edge n+HOLD_TIME+1
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] samp [0:8191];
    int                rst_edge = -100;
    logic [NUM_CH-1:0] m_pf;
    logic [NUM_CH-1:0] m_active;
    logic [NUM_CH-1:0] m_indet;
    int                m_off [NUM_CH];
    logic [NUM_CH-1:0] m_led;
    logic [NUM_CH-1:0] m_evt;
    logic              m_any;

    function automatic logic pir_s_at(int m, int ch);
        if (m - 2 > rst_edge) return samp[m-2][ch];
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        logic              tog;
        logic              pf;
        logic [NUM_CH-1:0] evt;
        ecnt++;
        evt = '0;
        if (reset) begin
            rst_edge = ecnt;
            m_pf     = '0;
            m_active = '0;
            m_indet  = '0;
            m_led    = '0;
            m_evt    = '0;
            m_any    = 1'b0;
        end else begin
            samp[ecnt] = pir_in;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                pf  = m_pf[ch];
                tog = 1'b1;
                for (int k = 0; k < DEB_CYCLES; k++) begin
                    if (ecnt - k <= rst_edge) tog = 1'b0;
                    else if (pir_s_at(ecnt - k, ch) == pf) tog = 1'b0;
                end
                if (!ch_enable[ch]) begin
                    m_active[ch] = 1'b0;
                    m_indet[ch]  = 1'b0;
                end else if (pf) begin
                    if (!m_indet[ch]) evt[ch] = 1'b1;
                    m_indet[ch]  = 1'b1;
                    m_active[ch] = 1'b1;
                end else if (m_indet[ch]) begin
                    m_indet[ch] = 1'b0;
                    m_off[ch]   = ecnt + HOLD_TIME + 1;
                end else if (m_active[ch] && ecnt == m_off[ch]) begin
                    m_active[ch] = 1'b0;
                end
                if (tog) m_pf[ch] = ~pf;
            end
            m_led = {NUM_CH{force_on}} | m_active;
            m_evt = evt;
            m_any = |m_active;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ecnt > 0) begin
            chk("model_led", 32'(led_out), 32'(m_led));
            chk("model_evt", 32'(motion_evt), 32'(m_evt));
            chk("model_any", 32'(any_active), 32'(m_any));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int lat;
        int fall_at;
        int evts;
        int drops;
        int g;

        // Reset with everything asserted: outputs stay low
        reset     = 1'b1;
        pir_in    = 2'b11;
        force_on  = 1'b1;
        ch_enable = 2'b11;
        repeat (3) begin
            tick();
            chk("rst_led", 32'(led_out), 0);
            chk("rst_evt", 32'(motion_evt), 0);
            chk("rst_any", 32'(any_active), 0);
        end
        reset    = 1'b0;
        pir_in   = 2'b00;
        force_on = 1'b0;
        tick();
        chk("rel_led", 32'(led_out), 0);
        chk("rel_evt", 32'(motion_evt), 0);
        chk("rel_any", 32'(any_active), 0);
        tick(2);

        // Basic cycle on channel 0: high for 20 samples then low
        pir_in[0] = 1'b1;
        lat = -1; fall_at = -1; evts = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (motion_evt[0]) evts++;
            if (lat < 0 && led_out[0]) begin
                lat = k;
                chk("basic_rise_evt", 32'(motion_evt), 32'h1);
            end
            if (lat > 0 && fall_at < 0 && !led_out[0]) fall_at = k;
            if (k == 20) pir_in[0] = 1'b0;
        end
        chk("basic_rise_lat", 32'(lat), 7);
        chk("basic_fall_edge", 32'(fall_at), 38);
        chk("basic_evt_count", 32'(evts), 1);
        chk("basic_led1", 32'(led_out[1]), 0);

        // Glitch of 3 samples on channel 1 is rejected
        g = 0;
        pir_in[1] = 1'b1;
        repeat (3) begin
            tick();
            if (led_out[1] || motion_evt[1]) g++;
        end
        pir_in[1] = 1'b0;
        repeat (12) begin
            tick();
            if (led_out[1] || motion_evt[1]) g++;
        end
        chk("glitch_reject", 32'(g), 0);

        // Retrigger in HOLD when the counter reads 5
        pir_in[0] = 1'b1;
        fall_at = -1; evts = 0; drops = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (motion_evt[0]) evts++;
            if (k >= 7 && k < 48 && !led_out[0]) drops++;
            if (k == 25) chk("retrig_evt", 32'(motion_evt[0]), 1);
            if (k >= 7 && fall_at < 0 && !led_out[0]) fall_at = k;
            if (k == 12) pir_in[0] = 1'b0;
            if (k == 18) pir_in[0] = 1'b1;
            if (k == 30) pir_in[0] = 1'b0;
        end
        chk("retrig_drops", 32'(drops), 0);
        chk("retrig_evts", 32'(evts), 2);
        chk("retrig_fall_edge", 32'(fall_at), 48);

        // Disable mid-HOLD, then override
        pir_in[0] = 1'b1;
        tick(12);
        pir_in[0] = 1'b0;
        tick(10);
        chk("hold_led_on", 32'(led_out[0]), 1);
        ch_enable[0] = 1'b0;
        tick();
        chk("dis_led", 32'(led_out), 0);
        chk("dis_evt", 32'(motion_evt), 0);
        chk("dis_any", 32'(any_active), 0);
        force_on = 1'b1;
        tick();
        chk("force_led", 32'(led_out), 32'h3);
        chk("force_any", 32'(any_active), 0);
        force_on = 1'b0;
        tick();
        chk("unforce_led", 32'(led_out), 0);
        ch_enable = 2'b11;
        tick(4);

        // Both channels detect together, then reset during HOLD
        pir_in = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 7) begin
                chk("conc_evt", 32'(motion_evt), 32'h3);
                chk("conc_led", 32'(led_out), 32'h3);
            end
            if (k == 10) pir_in = 2'b00;
        end
        chk("conc_hold_any", 32'(any_active), 1);
        reset    = 1'b1;
        force_on = 1'b1;
        tick();
        chk("midrst_led", 32'(led_out), 0);
        chk("midrst_any", 32'(any_active), 0);
        reset     = 1'b0;
        force_on  = 1'b0;
        pir_in[0] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lat < 0 && led_out[0]) lat = k;
        end
        chk("rerise_lat", 32'(lat), 7);
        pir_in = 2'b00;
        tick(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/smart_light_ctrl.md
# smart_light_ctrl

Parametrised multi-channel motion-activated lighting controller. It is the successor to the fixed two-channel PIR/LED block. Each of NUM_CH independent channels does the following:
- synchronises and debounces its PIR input;
- drives its light output through a detect/hold state machine with retrigger;
- supports per-channel enable and a global manual override.

It sits between the raw PIR sensor pins and the lighting drivers / alarm status logic.

## Interface
- NUM_CH, 2: number of independent PIR/light channels (≥1).
- HOLD_TIME, 50_000_000: hold-counter reload value in cycles (1 s at 50 MHz); 0 is legal.
- CNT_W, 26: hold-counter width; must satisfy HOLD_TIME < 2^CNT_W.
- DEB_CYCLES, 4: consecutive stable cycles needed to accept an input change (≥1).
- DEB_W, 3: debounce counter width; must satisfy DEB_CYCLES < 2^DEB_W.

- clk  in  1  system clock; one clock for the whole block.
- reset  in  1  synchronous, active-high reset.
- pir_in  in  NUM_CH  raw asynchronous PIR inputs, one bit per channel.
- ch_enable  in  NUM_CH  per-channel enable; 0 forces the channel idle.
- force_on  in  1  global manual override; all lights on while high.
- led_out  out  NUM_CH  registered light drive per channel.
- motion_evt  out  NUM_CH  one-cycle pulse per accepted detection.
- any_active  out  1  registered OR of all channel FSMs not in IDLE.

## Operation
- Reset (synchronous, clk edge with reset=1) clears:
  - sync flops, filtered level pir_f, debounce counters and hold counters to 0;
  - all states to IDLE;
  - led_out, motion_evt and any_active to 0.
  - Reset mid-hold drops the light on the next edge, even with force_on=1.
- Synchroniser: 2 flops per channel produce pir_s.
- Debounce, per channel:
  - If pir_s == pir_f, clear the counter.
  - Otherwise increment it. When the counter reaches DEB_CYCLES−1 while pir_s still differs, toggle pir_f and clear the counter.
  - pir_f therefore changes after DEB_CYCLES consecutive differing samples.
- FSM per channel, states IDLE, DETECTED, HOLD:
  - IDLE: pir_f=1 and ch_enable=1 → DETECTED, with motion_evt=1 that cycle.
  - DETECTED: pir_f=0 → HOLD, loading counter = HOLD_TIME.
  - HOLD:
    - pir_f=1 → DETECTED (retrigger), with motion_evt=1.
    - Else counter==0 → IDLE.
    - Else decrement the counter.
  - Retrigger always reloads the full HOLD_TIME on the next fall.
  - ch_enable=0 in any state → IDLE on the next edge, with no motion_evt. This has priority over all other transitions.
- Outputs, all registered from next-state values:
  - led_out[i] = force_on | (next_state_i != IDLE).
  - any_active = OR over channels of (next_state_i != IDLE). force_on is excluded.
- force_on does not alter FSM state or counters. Dropping force_on returns led_out to the FSM-derived value on the next edge.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.

## Timing
- Rise latency: pir_in first sampled high at edge 1.
  - pir_s=1 after edge 2.
  - pir_f=1 after edge DEB_CYCLES+2.
  - led_out=1 and motion_evt=1 after edge DEB_CYCLES+3 (default 7 cycles).
- Fall: pir_f falls after edge t.
  - HOLD is entered after edge t+1 with counter=HOLD_TIME.
  - IDLE and led_out=0 follow after edge t+HOLD_TIME+2.
  - The light is on for HOLD_TIME+1 cycles in HOLD.
- Glitches shorter than DEB_CYCLES cycles (after sync) produce no pir_f change.
- motion_evt is exactly 1 cycle wide. A new pulse requires a fresh transition into DETECTED.
- force_on → led_out: 1 cycle latency.
- ch_enable fall → led_out=0: 1 cycle latency, when force_on=0.

## Test plan
Bench parameters: NUM_CH=2, HOLD_TIME=10, DEB_CYCLES=4.
- Reset: hold reset 3 cycles with pir_in=2'b11 and force_on=1 → led_out, motion_evt and any_active all 0 throughout and on the first edge after release.
- Basic cycle:
  - Stimulus: pir_in[0]=1 for 20 cycles then 0, ch_enable=2'b11.
  - led_out[0] rises 7 cycles after the first high sample, with a single motion_evt[0] pulse on the same cycle.
  - led_out[0] falls 11+7 cycles after pir_in falls (debounce+sync 6, HOLD 11, exit 1).
  - led_out[1] stays 0.
- Glitch reject: pir_in[1] high for 3 cycles → led_out[1] and motion_evt[1] remain 0.
- Retrigger: re-assert pir_in[0] while in HOLD with counter=5 → DETECTED, second motion_evt[0] pulse, led_out[0] never drops; the hold after the next fall lasts the full 11 cycles.
- Enable/override: drop ch_enable[0] mid-HOLD → led_out[0]=0 next cycle, no evt. Then force_on=1 → led_out=2'b11 next cycle with any_active=0; release → 2'b00 next cycle.
- Concurrency and reset mid-hold: both channels detect on the same cycle → both motion_evt high together. Assert reset during HOLD → led_out=0 after that edge; a re-detect after release needs the full 7-cycle latency.
